// File: rtl/sr_chip_model.sv
`default_nettype none
// ============================================================================
// Module   : sr_chip_model
// Purpose  : Responder end of the clk_sr/din_sr/load_sr/dout_sr serial link.
//            It oversamples the link on clk_in and latches a parallel
//            configuration word on each load.
// Revision : 1.0 - initial release
// ============================================================================
module sr_chip_model #(
   parameter int WIDTH       = 170,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             clk_sr,
   input  logic             din_sr,
   input  logic             load_sr,
   output logic             dout_sr,
   output logic [WIDTH-1:0] cfg_out,
   output logic             cfg_valid,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             len_err
);

   localparam logic [1:0]       c_IDLE    = 2'd0;
   localparam logic [1:0]       c_SHIFT   = 2'd1;
   localparam logic [1:0]       c_LOAD    = 2'd2;
   localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(WIDTH);

   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_din_sync;
   logic [SYNC_STAGES-1:0] r_load_sync;
   logic                   r_clk_d;
   logic                   r_load_d;
   logic [WIDTH-1:0]       r_sr;
   logic [WIDTH-1:0]       r_cfg;
   logic                   r_dout;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_err;
   logic [1:0]             r_state;

   logic                   w_clk_rise;
   logic                   w_load_rise;
   logic [WIDTH-1:0]       w_sr_next;
   logic [CNT_W-1:0]       w_cnt_next;
   logic [1:0]             w_state_next;

   assign w_clk_rise  = r_clk_sync[SYNC_STAGES-1] & ~r_clk_d;
   assign w_load_rise = r_load_sync[SYNC_STAGES-1] & ~r_load_d;

   // A load in the same cycle as a shift sees the post-shift register and count.
   assign w_sr_next  = w_clk_rise ? {r_sr[WIDTH-2:0], r_din_sync[SYNC_STAGES-1]} : r_sr;
   assign w_cnt_next = (w_clk_rise && (r_cnt != c_MAX_CNT)) ? r_cnt + CNT_W'(1) : r_cnt;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_IDLE, c_SHIFT: begin
            if (w_load_rise)
               w_state_next = c_LOAD;
            else if (w_clk_rise)
               w_state_next = c_SHIFT;
         end
         c_LOAD: begin
            if (w_load_rise)
               w_state_next = c_LOAD;
            else if (w_clk_rise)
               w_state_next = c_SHIFT;
            else
               w_state_next = c_IDLE;
         end
         default: w_state_next = c_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_clk_sync  <= '0;
         r_din_sync  <= '0;
         r_load_sync <= '0;
         r_clk_d     <= 1'b0;
         r_load_d    <= 1'b0;
      end else begin
         r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], clk_sr};
         r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], din_sr};
         r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], load_sr};
         r_clk_d     <= r_clk_sync[SYNC_STAGES-1];
         r_load_d    <= r_load_sync[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_sr    <= '0;
         r_cfg   <= '0;
         r_dout  <= 1'b0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_state <= c_IDLE;
      end else begin
         r_sr    <= w_sr_next;
         r_dout  <= r_sr[WIDTH-1];
         r_state <= w_state_next;
         if (w_load_rise) begin
            r_cfg <= w_sr_next;
            r_cnt <= '0;
            if (w_cnt_next != c_MAX_CNT)
               r_err <= 1'b1;
         end else begin
            r_cnt <= w_cnt_next;
         end
      end
   end

   assign dout_sr   = r_dout;
   assign cfg_out   = r_cfg;
   assign cfg_valid = (r_state == c_LOAD);
   assign bit_cnt   = r_cnt;
   assign len_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sr_chip_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_chip_model
// Purpose  : Randomised serial-link bench for sr_chip_model against a
//            frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_chip_model;

   localparam int WIDTH       = 170;
   localparam int SYNC_STAGES = 2;
   localparam int CNT_W       = 8;

   logic             clk_in  = 1'b0;
   logic             rst     = 1'b1;
   logic             clk_sr  = 1'b0;
   logic             din_sr  = 1'b0;
   logic             load_sr = 1'b0;
   logic             dout_sr;
   logic [WIDTH-1:0] cfg_out;
   logic             cfg_valid;
   logic [CNT_W-1:0] bit_cnt;
   logic             len_err;

   sr_chip_model #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
   ) dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .clk_sr    (clk_sr),
      .din_sr    (din_sr),
      .load_sr   (load_sr),
      .dout_sr   (dout_sr),
      .cfg_out   (cfg_out),
      .cfg_valid (cfg_valid),
      .bit_cnt   (bit_cnt),
      .len_err   (len_err)
   );

   always #5 clk_in = ~clk_in;

   int tests  = 0;
   int fails  = 0;
   int vcount = 0;

   // Frame-level reference: register contents, shift count, latched word, sticky error.
   logic [WIDTH-1:0] m_sr;
   logic [WIDTH-1:0] m_cfg;
   int               m_cnt;
   bit               m_err;

   always @(negedge clk_in) if (cfg_valid) vcount++;

   task automatic check(string nm, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(int n);
      repeat (n) @(negedge clk_in);
   endtask

   function automatic int ph();
      return $urandom_range(SYNC_STAGES + 2, SYNC_STAGES + 4);
   endfunction

   function automatic logic [WIDTH-1:0] rand_word();
      logic [WIDTH-1:0] w;
      for (int i = 0; i < WIDTH; i++) w[i] = 1'($urandom_range(0, 1));
      return w;
   endfunction

   task automatic model_reset();
      m_sr  = '0;
      m_cfg = '0;
      m_cnt = 0;
      m_err = 1'b0;
   endtask

   task automatic model_shift(bit b);
      m_sr = {m_sr[WIDTH-2:0], b};
      if (m_cnt < WIDTH) m_cnt++;
   endtask

   task automatic model_load();
      if (m_cnt != WIDTH) m_err = 1'b1;
      m_cfg = m_sr;
      m_cnt = 0;
   endtask

   task automatic compare_all(string tag);
      check({tag, "_bit_cnt"},   WIDTH'(bit_cnt),   WIDTH'(m_cnt));
      check({tag, "_len_err"},   WIDTH'(len_err),   WIDTH'(m_err));
      check({tag, "_cfg_out"},   cfg_out,           m_cfg);
      check({tag, "_dout_sr"},   WIDTH'(dout_sr),   WIDTH'(m_sr[WIDTH-1]));
      check({tag, "_cfg_valid"}, WIDTH'(cfg_valid), WIDTH'(0));
   endtask

   // One clk_sr period; dout_sr is read just before the rise, as the controller does.
   task automatic send_bit(bit b, bit with_load, output bit rd);
      rd = dout_sr;
      check("dout_pre_shift", WIDTH'(dout_sr), WIDTH'(m_sr[WIDTH-1]));
      din_sr = b;
      cyc(ph());
      if (with_load) vcount = 0;
      clk_sr = 1'b1;
      if (with_load) load_sr = 1'b1;
      model_shift(b);
      if (with_load) model_load();
      cyc(ph());
      clk_sr  = 1'b0;
      load_sr = 1'b0;
      cyc(ph());
      if (with_load) begin
         check("simul_cfg_valid_pulses", WIDTH'(vcount), WIDTH'(1));
         compare_all("simul");
      end
   endtask

   task automatic do_load();
      vcount  = 0;
      load_sr = 1'b1;
      cyc(ph());
      load_sr = 1'b0;
      model_load();
      cyc(ph());
      check("load_cfg_valid_pulses", WIDTH'(vcount), WIDTH'(1));
      compare_all("load");
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(10);
      rst = 1'b0;
      model_reset();
      vcount = 0;
      cyc(3);
      compare_all("reset");
   endtask

   task automatic send_word(logic [WIDTH-1:0] w, int n, bit simul_last, output logic [WIDTH-1:0] reads);
      bit rd;
      reads = '0;
      for (int i = 0; i < n; i++) begin
         send_bit(w[WIDTH-1-i], simul_last && (i == n - 1), rd);
         reads[WIDTH-1-i] = rd;
      end
   endtask

   initial begin
      logic [WIDTH-1:0] w1;
      logic [WIDTH-1:0] w;
      logic [WIDTH-1:0] reads;
      bit               rd;
      int               n;
      bit               simul;

      w1 = {1'b1, 169'b1011};
      model_reset();

      // Reset held 100 ns while idle.
      cyc(10);
      rst = 1'b0;
      cyc(4);
      compare_all("por");
      check("por_cfg_out_zero", cfg_out, '0);
      check("por_no_cfg_valid", WIDTH'(vcount), WIDTH'(0));

      // Full frame of the known word.
      send_word(w1, WIDTH, 1'b0, reads);
      check("frame1_bit_cnt_full", WIDTH'(bit_cnt), WIDTH'(170));
      do_load();
      check("frame1_cfg_literal", cfg_out, w1);
      check("frame1_len_err_zero", WIDTH'(len_err), WIDTH'(0));

      // All-zero frame reads back the previous word bit by bit.
      send_word('0, WIDTH, 1'b0, reads);
      check("frame2_readback_literal", reads, w1);
      do_load();
      check("frame2_cfg_zero", cfg_out, '0);

      // Load coincident with the 170th clk_sr rise.
      w = rand_word();
      send_word(w, WIDTH, 1'b1, reads);
      check("simul_cfg_has_last_bit", cfg_out, w);
      check("simul_len_err_zero", WIDTH'(len_err), WIDTH'(0));

      // Short frame sets the sticky error; a correct frame does not clear it.
      w = rand_word();
      send_word(w, 100, 1'b0, reads);
      do_load();
      check("short_len_err_set", WIDTH'(len_err), WIDTH'(1));
      w = rand_word();
      send_word(w, WIDTH, 1'b0, reads);
      do_load();
      check("short_len_err_sticky", WIDTH'(len_err), WIDTH'(1));

      // Reset in mid-frame, then a clean frame.
      w = rand_word();
      send_word(w, 80, 1'b0, reads);
      do_reset();
      w = rand_word();
      send_word(w, WIDTH, 1'b0, reads);
      check("rst_frame_dout_zeros", reads, '0);
      check("rst_frame_bit_cnt", WIDTH'(bit_cnt), WIDTH'(170));
      do_load();
      check("rst_frame_cfg_exact", cfg_out, w);
      check("rst_frame_len_err_zero", WIDTH'(len_err), WIDTH'(0));

      // Randomised frames, some with wrong lengths or coincident loads.
      for (int f = 0; f < 4; f++) begin
         n     = ($urandom_range(0, 2) == 0) ? $urandom_range(150, 190) : WIDTH;
         simul = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < n; i++)
            send_bit(1'($urandom_range(0, 1)), simul && (i == n - 1), rd);
         if (!simul) do_load();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sr_chip_model.md
Name: sr_chip_model

Overview:
- Synthesizable model of the on-chip configuration shift register that the shift-register controller drives. It is the responder end of the clk_sr/din_sr/load_sr/dout_sr serial link.
- Inputs are oversampled on the FPGA system clock, serial data is shifted in, and the register is latched to a parallel configuration word on load. The previously held bits are returned on dout_sr.
- Used in loopback firmware tests and benches in place of the ASIC. Inputs are single-ended, taken after the IBUFDS; outputs are single-ended, fed to the OBUFDS.

Parameters:
- WIDTH, 170, length of the shift and configuration registers in bits.
- SYNC_STAGES, 2, synchronizer flops on each serial input (min 2).
- CNT_W, 8, width of bit_cnt; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_in  input  1  system clock.
- rst  input  1  reset, asynchronous and active-high.
- clk_sr  input  1  serial shift clock from controller, asynchronous to clk_in.
- din_sr  input  1  serial data from controller.
- load_sr  input  1  load strobe from controller.
- dout_sr  output  1  serial data back to controller (sr[WIDTH-1]).
- cfg_out  output  WIDTH  latched configuration word.
- cfg_valid  output  1  one-cycle pulse when cfg_out updates.
- bit_cnt  output  CNT_W  shifts since last load, saturating at WIDTH.
- len_err  output  1  sticky; set when a load occurs with bit_cnt != WIDTH.

Behaviour:
- Reset, asynchronous: dout_sr=0, cfg_out=0, cfg_valid=0, bit_cnt=0, len_err=0, sr=0, synchronizers=0, state=IDLE. Reset mid-frame discards partial shifts; there is no recovery of the old sr contents.
- Synchronization: clk_sr, din_sr and load_sr each pass SYNC_STAGES flops. A further flop per line is used for edge detection.
  - clk_rise = synced clk_sr 0->1; load_rise = synced load_sr 0->1.
  - Input timing requirement: clk_sr and load_sr high and low phases each ≥ SYNC_STAGES+2 clk_in cycles. din_sr must be stable for that window around the clk_sr rising edge.
- Shift on clk_rise:
  - sr <= {sr[WIDTH-2:0], din_sync}, i.e. MSB-first in; the first bit sent ends in sr[WIDTH-1] after WIDTH shifts.
  - bit_cnt <= min(bit_cnt+1, WIDTH).
- dout_sr: registered copy of sr[WIDTH-1], updated the cycle after sr changes. Latency from the clk_sr input edge to dout_sr is SYNC_STAGES+2 clk_in cycles. Controller reads dout_sr before the next clk_sr rise.
- Load on load_rise:
  - cfg_out <= sr; cfg_valid=1 for exactly one cycle; bit_cnt <= 0.
  - If bit_cnt != WIDTH, then len_err <= 1. len_err clears only on rst.
  - sr is retained, not cleared, so the next frame reads back the last loaded word.
- Simultaneous clk_rise and load_rise in the same cycle:
  - Shift happens first; cfg_out captures the post-shift value.
  - bit_cnt <= 0.
  - len_err is evaluated with bit_cnt+1.
- State machine:
  - IDLE: bit_cnt=0. clk_rise -> SHIFT. load_rise -> LOAD.
  - SHIFT: clk_rise shifts. load_rise -> LOAD.
  - LOAD: one cycle; asserts cfg_valid; -> IDLE unconditionally. A clk_rise arriving in LOAD is still shifted and moves the next state to SHIFT.
- bit_cnt saturates at WIDTH. Further shifts continue to move sr but do not increment the count.
- load_sr held high: only the single rising edge acts; no repeated loads.

Test Plan:
- rst pulse high 100 ns while idle -> all outputs 0; state IDLE; cfg_valid never asserts.
- Shift 170 bits of {1'b1,169'b1011} MSB first, then pulse load -> cfg_out=={1'b1,169'b1011}; one cfg_valid pulse; bit_cnt returns 0; len_err=0.
- Second frame of 170 zeros after the above -> dout_sr sequence at each clk_sr equals 1, then 165 zeros, then 1,0,1,1; final cfg_out==0.
- Load after only 100 shifts -> cfg_valid pulses; len_err=1 and stays 1 through a subsequent correct 170-bit frame until rst.
- clk_sr and load_sr rising in the same clk_in cycle on shift 170 -> cfg_out includes the 170th bit; len_err=0.
- Assert rst after 80 shifts, then run a full 170-bit frame -> cfg_out equals the new word exactly; bit_cnt reached 170; dout_sr emitted 170 zeros.
